// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared definitions for the BCD-to-binary converter:
//   - state_t          : converter FSM state encoding (IDLE, SHIFT, DONE)
//   - BCD_DIGIT_W      : width of one packed BCD digit
//   - BCD_ADJ_THRESH   : nibble value at or above which the un-adjust applies
//   - BCD_ADJ_SUB      : amount subtracted from an adjusted nibble
//   - BCD_MAX_DIGIT    : largest legal decimal digit
//   - req_bin_w()      : binary width needed to hold 10^digits - 1
// -----------------------------------------------------------------------------
package chip8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                     BCD_DIGIT_W    = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_SUB    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;

    // Smallest w with 2^w >= 10^digits, i.e. ceil(log2(10^digits)).
    // Valid for digits up to 18 (10^18 still fits a signed 64-bit value).
    function automatic int req_bin_w(input int digits);
        longint p;
        int     w;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        w = 0;
        while ((64'sd1 <<< w) < p) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bin_from_bcd_if.sv
// -----------------------------------------------------------------------------
// bin_from_bcd_if
// Start/busy/done handshake between the CPU datapath and the BCD-to-binary
// converter.
//   start : request a conversion (master -> slave)
//   bcd   : packed BCD digits, digit 0 in [3:0] (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse when bin/err update (slave -> master)
//   bin   : binary result, held until the next done (slave -> master)
//   err   : invalid-digit flag, qualified by done (slave -> master)
// Modports: master = CPU side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_from_bcd_if
    import chip8_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);

    logic                          start;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic                          busy;
    logic                          done;
    logic [BIN_W-1:0]              bin;
    logic                          err;

    modport master (
        output start, bcd,
        input  busy, done, bin, err
    );

    modport slave (
        input  start, bcd,
        output busy, done, bin, err
    );

endinterface

// File: rtl/bcd_digit_unadj.sv
// -----------------------------------------------------------------------------
// bcd_digit_unadj
// Combinational per-nibble correction for reverse double-dabble: after the
// right shift, a nibble that is >= 8 received a bit worth 8 that should be
// worth 5 in decimal, so 3 is subtracted from it.
//   digit : nibble after the shift
//   adj   : corrected nibble
// -----------------------------------------------------------------------------
module bcd_digit_unadj
    import chip8_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    always_comb begin
        if (digit >= BCD_ADJ_THRESH) begin
            adj = digit - BCD_ADJ_SUB;
        end else begin
            adj = digit;
        end
    end

endmodule

// File: rtl/bin_from_bcd.sv
// -----------------------------------------------------------------------------
// bin_from_bcd
// Sequential BCD-to-binary converter using reverse double-dabble. The scratch
// register holds {bcd digits, binary field}; each SHIFT cycle shifts it right
// by one and un-adjusts every digit nibble. After BIN_W shifts the binary
// field holds the result.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : bin_from_bcd_if.slave (start, bcd, busy, done, bin, err)
//
// Optional build macro BIN_FROM_BCD_CHECK_EN: digits > 9 are detected on the
// accepted start; such a request skips the shifting and completes with
// err=1, bin=0. Without the macro err is tied low and invalid digits go
// through the normal sequence.
// -----------------------------------------------------------------------------
module bin_from_bcd
    import chip8_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
)
(
    input  logic           clk,
    input  logic           rst,
    bin_from_bcd_if.slave  bus
);

    localparam int               DIG_FIELD_W = BCD_DIGIT_W * DIGITS;
    localparam int               SCR_W       = DIG_FIELD_W + BIN_W;
    localparam int               CNT_W       = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER   = CNT_W'(BIN_W - 1);

    generate
        if (BIN_W != req_bin_w(DIGITS)) begin : g_bad_bin_w
            $error("bin_from_bcd: BIN_W must equal ceil(log2(10**DIGITS))");
        end
    endgenerate

    state_t                 state;
    state_t                 state_next;
    logic [SCR_W-1:0]       scratch;
    logic [SCR_W-1:0]       shifted;
    logic [DIG_FIELD_W-1:0] digits_adj;
    logic [CNT_W-1:0]       count;
    logic                   done_q;
    logic [BIN_W-1:0]       bin_q;

    // Right shift with zero fill; the digit nibbles of the shifted value are
    // then corrected independently.
    assign shifted = {1'b0, scratch[SCR_W-1:1]};

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_unadj
            bcd_digit_unadj u_unadj (
                .digit (shifted[BIN_W + i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adj   (digits_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

`ifdef BIN_FROM_BCD_CHECK_EN
    logic start_bad;
    logic inv_q;
    logic err_q;

    always_comb begin
        start_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                start_bad = 1'b1;
            end
        end
    end
`endif

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count == LAST_ITER) begin
                    state_next = DONE;
                end
`ifdef BIN_FROM_BCD_CHECK_EN
                // Invalid input completes after a single SHIFT cycle.
                if (inv_q) begin
                    state_next = DONE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and result registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            scratch <= '0;
            done_q  <= 1'b0;
            bin_q   <= '0;
`ifdef BIN_FROM_BCD_CHECK_EN
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            // done is raised on the edge that leaves DONE, together with bin.
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        scratch <= {bus.bcd, {BIN_W{1'b0}}};
                        count   <= '0;
`ifdef BIN_FROM_BCD_CHECK_EN
                        inv_q   <= start_bad;
`endif
                    end
                end
                SHIFT: begin
                    scratch <= {digits_adj, shifted[BIN_W-1:0]};
                    count   <= count + 1'b1;
                end
                DONE: begin
`ifdef BIN_FROM_BCD_CHECK_EN
                    bin_q <= inv_q ? '0 : scratch[BIN_W-1:0];
                    err_q <= inv_q;
`else
                    bin_q <= scratch[BIN_W-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.bin  = bin_q;
`ifdef BIN_FROM_BCD_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_from_bcd.sv
// -----------------------------------------------------------------------------
// tb_bin_from_bcd
// Directed self-checking bench for bin_from_bcd (DIGITS=3, BIN_W=10).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bin_from_bcd;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    bin_from_bcd_if #(.DIGITS(3), .BIN_W(10)) bif ();

    bin_from_bcd #(.DIGITS(3), .BIN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One single-cycle start; returns result, error flag, cycles from the
    // accepting edge to the observed done, and how many cycles busy was high.
    task automatic convert(input logic [11:0] value, output logic [9:0] b,
                           output logic e, output int lat, output int busy_cnt);
        @(negedge clk);
        bif.bcd   = value;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (bif.done !== 1'b1 && lat < 40) begin
            if (bif.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        b = bif.bin;
        e = bif.err;
        @(negedge clk);
        check("done_single_cycle", {31'b0, bif.done}, 32'd0);
    endtask

    initial begin
        logic [9:0] b;
        logic       e;
        int         lat;
        int         busy_cnt;
        int         ndone;
        int         done_lat;
        int         bad_busy;
        int         prev_lat;
        logic       prev_busy;
        logic [9:0] got_bin;

        rst       = 1'b1;
        bif.start = 1'b0;
        bif.bcd   = 12'h000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {31'b0, bif.busy}, 32'd0);
        check("rst_done", {31'b0, bif.done}, 32'd0);
        check("rst_bin",  {22'b0, bif.bin},  32'd0);
        check("rst_err",  {31'b0, bif.err},  32'd0);
        rst = 1'b0;

        // 255: latency 11, busy 10 cycles
        convert(12'h255, b, e, lat, busy_cnt);
        check("h255_bin",  {22'b0, b}, 32'd255);
        check("h255_err",  {31'b0, e}, 32'd0);
        check("h255_lat",  lat,        32'd11);
        check("h255_busy", busy_cnt,   32'd10);

        // Upper and lower bounds
        convert(12'h999, b, e, lat, busy_cnt);
        check("h999_bin", {22'b0, b}, 32'd999);
        convert(12'h000, b, e, lat, busy_cnt);
        check("h000_bin", {22'b0, b}, 32'd0);
        check("h000_lat", lat,        32'd11);

        // Every valid input against the decimal value of its digits
        for (int d2 = 0; d2 < 10; d2++) begin
            for (int d1 = 0; d1 < 10; d1++) begin
                for (int d0 = 0; d0 < 10; d0++) begin
                    convert({d2[3:0], d1[3:0], d0[3:0]}, b, e, lat, busy_cnt);
                    check("sweep_bin", {22'b0, b}, d2 * 100 + d1 * 10 + d0);
                end
            end
        end

        // Start during a conversion is ignored
        @(negedge clk);
        bif.bcd   = 12'h042;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        ndone    = 0;
        done_lat = -1;
        got_bin  = '0;
        for (int l = 0; l <= 30; l++) begin
            if (bif.done === 1'b1) begin
                ndone++;
                if (done_lat < 0) begin
                    done_lat = l;
                    got_bin  = bif.bin;
                end
            end
            if (l == 3) begin
                bif.start = 1'b1;
                bif.bcd   = 12'h777;
            end
            if (l == 4) bif.start = 1'b0;
            @(negedge clk);
        end
        check("ignore_ndone", ndone,            32'd1);
        check("ignore_bin",   {22'b0, got_bin}, 32'd42);
        check("ignore_lat",   done_lat,         32'd11);

        // Reset in the middle of a conversion
        @(negedge clk);
        bif.bcd   = 12'h123;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, bif.busy}, 32'd0);
        check("midrst_done", {31'b0, bif.done}, 32'd0);
        check("midrst_bin",  {22'b0, bif.bin},  32'd0);
        check("midrst_err",  {31'b0, bif.err},  32'd0);
        rst   = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (bif.done === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 32'd0);
        convert(12'h123, b, e, lat, busy_cnt);
        check("after_rst_bin", {22'b0, b}, 32'd123);

        // Start held high: a new conversion every 12 cycles
        @(negedge clk);
        bif.bcd   = 12'h500;
        bif.start = 1'b1;
        @(negedge clk);
        ndone     = 0;
        bad_busy  = 0;
        prev_lat  = -1;
        prev_busy = 1'b0;
        for (int l = 0; l <= 50; l++) begin
            if (bif.done === 1'b1) begin
                ndone++;
                check("held_bin", {22'b0, bif.bin}, 32'd500);
                check("held_lat", l, (prev_lat < 0) ? 32'd11 : prev_lat + 12);
                prev_lat = l;
                if (bif.busy !== 1'b0 || prev_busy !== 1'b0) bad_busy++;
            end
            prev_busy = bif.busy;
            @(negedge clk);
        end
        bif.start = 1'b0;
        check("held_ndone",    ndone,    32'd4);
        check("held_busy_off", bad_busy, 32'd0);
        repeat (20) @(negedge clk);

        // Invalid digit
        convert(12'h1A3, b, e, lat, busy_cnt);
`ifdef BIN_FROM_BCD_CHECK_EN
        check("bad_digit_err", {31'b0, e}, 32'd1);
        check("bad_digit_bin", {22'b0, b}, 32'd0);
        check("bad_digit_lat", lat,        32'd2);
`else
        check("bad_digit_err", {31'b0, e}, 32'd0);
        check("bad_digit_lat", lat,        32'd11);
`endif

        // A valid conversion still works afterwards
        convert(12'h007, b, e, lat, busy_cnt);
        check("final_bin", {22'b0, b}, 32'd7);
        check("final_err", {31'b0, e}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
